spi_mst: RTL

SPI master (initiator) that drives the LV-side SPI slave register port. It accepts one register read or write request from on-chip control logic and serialises it as a 24-bit mode-0 frame: command, data, then CRC-8. It captures the slave's reply and checks its CRC. It is the far-end counterpart of spi_slv and is used by the system controller and by the verification bench to access LV registers.

---
 rtl/spi_mst.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_mst.sv
// SPI mode-0 master for the LV register port: sends one 24-bit frame
// {cmd, data, crc8} per request and returns read data plus a reply-CRC verdict.
module spi_mst #(
  parameter int SCLK_DIV = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_spi_mst_en,
  input  logic       i_req_vld,
  output logic       o_req_rdy,
  input  logic       i_req_wr,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_vld,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_crc_err,
  output logic       o_spi_sclk,
  output logic       o_spi_csb,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // CRC-8, poly 0x07, init 0x00, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] msg);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ (((c[7] ^ msg[i]) == 1'b1) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_cnt;
  logic [22:0]      tx_sr;
  logic [15:0]      rx_sr;
  logic [7:0]       cmd_q;
  logic             rsp_pend;

  logic [7:0]  req_cmd;
  logic [7:0]  req_data;
  logic [23:0] req_frame;

  always_comb begin
    req_cmd   = {i_req_wr, i_req_addr};
    req_data  = i_req_wr ? i_req_wdata : 8'h00;
    req_frame = {req_cmd, req_data, crc8({req_cmd, req_data})};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the values from before the clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      cmd_q         <= '0;
      rsp_pend      <= 1'b0;
      o_req_rdy     <= 1'b0;
      o_rsp_vld     <= 1'b0;
      o_rsp_rdata   <= 8'h00;
      o_rsp_crc_err <= 1'b0;
      o_spi_sclk    <= 1'b0;
      o_spi_csb     <= 1'b1;
      o_spi_mosi    <= 1'b0;
    end else begin
      o_rsp_vld <= 1'b0;
      rsp_pend  <= 1'b0;

      // Response is published one cycle after CSB rises.
      if (rsp_pend) begin
        o_rsp_vld     <= 1'b1;
        o_rsp_rdata   <= cmd_q[7] ? 8'h00 : rx_sr[15:8];
        o_rsp_crc_err <= (crc8({cmd_q, rx_sr[15:8]}) != rx_sr[7:0]);
      end

      case (state)
        ST_IDLE: begin
          if (i_req_vld && o_req_rdy) begin
            state      <= ST_SETUP;
            o_req_rdy  <= 1'b0;
            o_spi_csb  <= 1'b0;
            o_spi_sclk <= 1'b0;
            o_spi_mosi <= req_frame[23];
            tx_sr      <= req_frame[22:0];
            cmd_q      <= req_cmd;
            cnt        <= CNT_W'(CS_SETUP - 1);
          end else begin
            o_req_rdy <= i_spi_mst_en;
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            state   <= ST_SHIFT;
            cnt     <= CNT_W'(SCLK_DIV - 1);
            bit_cnt <= 5'd23;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= CNT_W'(SCLK_DIV - 1);
            if (!o_spi_sclk) begin
              o_spi_sclk <= 1'b1;
              rx_sr      <= {rx_sr[14:0], i_spi_miso};
            end else begin
              o_spi_sclk <= 1'b0;
              if (bit_cnt == 5'd0) begin
                state      <= ST_HOLD;
                cnt        <= CNT_W'(CS_HOLD - 1);
                o_spi_mosi <= 1'b0;
              end else begin
                bit_cnt    <= bit_cnt - 5'd1;
                o_spi_mosi <= tx_sr[22];
                tx_sr      <= {tx_sr[21:0], 1'b0};
              end
            end
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            state     <= ST_GAP;
            o_spi_csb <= 1'b1;
            rsp_pend  <= 1'b1;
            cnt       <= CNT_W'(CS_GAP - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == '0) begin
            state     <= ST_IDLE;
            o_req_rdy <= i_spi_mst_en;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          o_req_rdy  <= 1'b0;
          o_spi_csb  <= 1'b1;
          o_spi_sclk <= 1'b0;
          o_spi_mosi <= 1'b0;
        end
      endcase
    end
  end

endmodule
